// File: rtl/wavetrace_cmd_decoder.sv
// Purpose : wavetrace host-link command responder; UART bytes -> register bus, read data -> UART bytes.
// Latency : reg_wr/reg_rd one cycle after the last command byte; response byte 0 one cycle after reg_rdata_valid.
// Backpr. : in_ready drops while a bus access or response is in flight; response bytes held on out_ready=0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     received byte stream (valid/ready)
//   out_valid/out_ready/out_data  response byte stream (valid/ready)
//   reg_wr, reg_rd                one-cycle bus strobes
//   reg_addr, reg_wdata           word address and write data, held until the next command
//   reg_rdata, reg_rdata_valid    read return data and its strobe
//   err_count                     saturating count of discarded words/commands and read timeouts
module wavetrace_cmd_decoder #(
    parameter int          AddrBits      = 16,
    parameter int          TimeoutCycles = 100000,
    parameter logic [31:0] WriteHdr      = 32'hABCD0001,
    parameter logic [31:0] ReadHdr       = 32'hABCD0002
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                reg_wr,
    output logic                reg_rd,
    output logic [AddrBits-1:0] reg_addr,
    output logic [31:0]         reg_wdata,
    input  logic [31:0]         reg_rdata,
    input  logic                reg_rdata_valid,
    output logic [7:0]          err_count
);

    localparam int CntW = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_DATA,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_SEND
    } state_t;

    state_t              r_state;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;      // first three bytes of the word being assembled
    logic                r_is_read;
    logic [CntW-1:0]     r_idle_cnt;   // shared: byte-idle timer and read-return timer
    logic [7:0]          r_err_cnt;
    logic                r_reg_wr;
    logic                r_reg_rd;
    logic [AddrBits-1:0] r_reg_addr;
    logic [31:0]         r_reg_wdata;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
    logic [31:0]         r_rsp;        // remaining response bytes, byte 0 in [7:0]
    logic [1:0]          r_out_idx;

    logic        w_rx_state;
    logic        w_accept;
    logic [31:0] w_word;
    logic        w_word_done;
    logic        w_partial;
    logic        w_idle_expired;
    logic        w_err_event;
    logic [31:0] w_rsp_word;

    assign w_rx_state     = (r_state == S_HDR) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_accept       = in_valid && in_ready;
    assign w_word         = {in_data, r_shift};
    assign w_word_done    = w_accept && (r_byte_cnt == 2'd3);
    // Idle timing is only meaningful once something has been started.
    assign w_partial      = w_rx_state && !((r_state == S_HDR) && (r_byte_cnt == 2'd0));
    assign w_idle_expired = (r_idle_cnt == CntW'(TimeoutCycles - 1));
    assign w_rsp_word     = reg_rdata_valid ? reg_rdata : 32'hDEADBEEF;

    assign w_err_event = (w_word_done && (r_state == S_HDR) && (w_word != WriteHdr) && (w_word != ReadHdr))
                      || (!w_accept && w_partial && w_idle_expired)
                      || ((r_state == S_RD_WAIT) && !reg_rdata_valid && w_idle_expired);

    // Outputs are masked by rst so nothing handshakes or strobes in the reset cycle itself.
    assign in_ready  = w_rx_state && !rst;
    assign out_valid = r_out_valid && !rst;
    assign reg_wr    = r_reg_wr && !rst;
    assign reg_rd    = r_reg_rd && !rst;
    assign out_data  = r_out_data;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign err_count = r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HDR;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 24'd0;
            r_is_read   <= 1'b0;
            r_idle_cnt  <= '0;
            r_err_cnt   <= 8'd0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_rsp       <= 32'd0;
            r_out_idx   <= 2'd0;
        end else begin
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;

            case (r_state)
                S_HDR, S_ADDR, S_DATA: begin
                    if (w_accept) begin
                        r_idle_cnt <= '0;
                        r_shift    <= w_word[31:8];
                        r_byte_cnt <= r_byte_cnt + 2'd1;   // wraps to 0 on a complete word
                        if (r_byte_cnt == 2'd3) begin
                            case (r_state)
                                S_HDR: begin
                                    if (w_word == WriteHdr) begin
                                        r_is_read <= 1'b0;
                                        r_state   <= S_ADDR;
                                    end else if (w_word == ReadHdr) begin
                                        r_is_read <= 1'b1;
                                        r_state   <= S_ADDR;
                                    end
                                end
                                S_ADDR: begin
                                    r_reg_addr <= w_word[AddrBits+1:2];
                                    if (r_is_read) begin
                                        r_reg_rd <= 1'b1;
                                        r_state  <= S_RD_REQ;
                                    end else begin
                                        r_state  <= S_DATA;
                                    end
                                end
                                default: begin
                                    r_reg_wdata <= w_word;
                                    r_reg_wr    <= 1'b1;
                                    r_state     <= S_WR;
                                end
                            endcase
                        end
                    end else if (w_partial) begin
                        if (w_idle_expired) begin
                            r_idle_cnt <= '0;
                            r_byte_cnt <= 2'd0;
                            r_state    <= S_HDR;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + CntW'(1);
                        end
                    end else begin
                        r_idle_cnt <= '0;
                    end
                end

                S_WR: begin
                    r_state <= S_HDR;
                end

                S_RD_REQ: begin
                    // A return strobe coincident with reg_rd lands here and is dropped.
                    r_idle_cnt <= '0;
                    r_state    <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (reg_rdata_valid || w_idle_expired) begin
                        r_rsp       <= w_rsp_word;
                        r_out_data  <= w_rsp_word[7:0];
                        r_out_valid <= 1'b1;
                        r_out_idx   <= 2'd0;
                        r_idle_cnt  <= '0;
                        r_state     <= S_RD_SEND;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + CntW'(1);
                    end
                end

                S_RD_SEND: begin
                    if (r_out_valid && out_ready) begin
                        if (r_out_idx == 2'd3) begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_HDR;
                        end else begin
                            r_out_idx  <= r_out_idx + 2'd1;
                            r_rsp      <= {8'd0, r_rsp[31:8]};
                            r_out_data <= r_rsp[15:8];
                        end
                    end
                end

                default: begin
                    r_state <= S_HDR;
                end
            endcase

            if (w_err_event && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wavetrace_cmd_decoder.sv
module tb_wavetrace_cmd_decoder;

    localparam int          T        = 40;
    localparam logic [31:0] WR_HDR   = 32'hABCD0001;
    localparam logic [31:0] RD_HDR   = 32'hABCD0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata = 32'd0;
    logic        reg_rdata_valid = 1'b0;
    logic [7:0]  err_count;

    wavetrace_cmd_decoder #(.AddrBits(16), .TimeoutCycles(T), .WriteHdr(WR_HDR), .ReadHdr(RD_HDR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_rdata_valid(reg_rdata_valid), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Observations
    logic [47:0] got_wr[$];
    logic [15:0] got_rd[$];
    logic [7:0]  got_out[$];
    int          hold_viol = 0;
    logic        wr_ir_at = 1'b1, wr_ir_next = 1'b0, cap_next = 1'b0;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0]  prev_d = 8'd0;

    // Stimulus knobs
    int          gap_max = 0;
    int          or_mode = 0;
    logic        rsp_en = 1'b1;
    logic        rsp_junk = 1'b0;
    int          rsp_delay = 1;
    logic [31:0] rsp_val = 32'd0;

    // Reference model: word address is the byte address divided by 4, modulo 2^16.
    function automatic logic [15:0] model_addr(input logic [31:0] baddr);
        return 16'((baddr >> 2) % 32'h10000);
    endfunction

    function automatic logic [7:0] model_byte(input logic [31:0] v, input int i);
        return 8'((v >> (8 * i)) & 32'hFF);
    endfunction

    always @(negedge clk) begin
        if (reg_wr) begin
            got_wr.push_back({reg_addr, reg_wdata});
            wr_ir_at = in_ready;
            cap_next = 1'b1;
        end else if (cap_next) begin
            wr_ir_next = in_ready;
            cap_next   = 1'b0;
        end
        if (reg_rd) got_rd.push_back(reg_addr);
        if (out_valid && out_ready) got_out.push_back(out_data);
        if (prev_v && !prev_r && !rst && (!out_valid || out_data != prev_d)) hold_viol++;
        prev_v = out_valid;
        prev_r = out_ready;
        prev_d = out_data;
    end

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Register-bus read responder
    initial begin
        forever begin
            @(negedge clk);
            if (reg_rd) begin
                if (rsp_junk) begin
                    reg_rdata       = 32'hBAD0BAD0;
                    reg_rdata_valid = 1'b1;
                end
                @(negedge clk);
                reg_rdata_valid = 1'b0;
                repeat (rsp_delay - 1) @(negedge clk);
                if (rsp_en) begin
                    reg_rdata       = rsp_val;
                    reg_rdata_valid = 1'b1;
                    @(negedge clk);
                    reg_rdata_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int budget = 0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (int'($urandom_range(0, gap_max))) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte: in_ready stuck low, got 0 expected 1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(model_byte(w, i));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_wr.delete();
        got_rd.delete();
        got_out.delete();
        hold_viol = 0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (got_out.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_wr(input int n);
        int k = 0;
        while (got_wr.size() < n && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        vectors++; if ({reg_wr, reg_rd} !== 2'b00) begin miscompares++; $display("FAIL reset strobes: got %b expected 00", {reg_wr, reg_rd}); end
        vectors++; if (reg_addr !== 16'd0 || reg_wdata !== 32'd0) begin miscompares++; $display("FAIL reset bus: got %h/%h expected 0/0", reg_addr, reg_wdata); end
        vectors++; if (out_data !== 8'd0 || err_count !== 8'd0) begin miscompares++; $display("FAIL reset out_data/err: got %h/%h expected 0/0", out_data, err_count); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset release in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_write();
        do_reset();
        gap_max = 0;
        or_mode = 0;
        send_word(WR_HDR);
        send_word(32'h14);
        send_word(32'h1);
        wait_wr(1);
        vectors++; if (got_wr.size() != 1) begin miscompares++; $display("FAIL write pulses: got %0d expected 1", got_wr.size()); end
        if (got_wr.size() >= 1) begin
            vectors++; if (got_wr[0] !== {16'd5, 32'd1}) begin miscompares++; $display("FAIL write bus: got %h expected %h", got_wr[0], {16'd5, 32'd1}); end
        end
        vectors++; if (wr_ir_at !== 1'b0 || wr_ir_next !== 1'b1) begin miscompares++; $display("FAIL write in_ready: got %b%b expected 01", wr_ir_at, wr_ir_next); end
        vectors++; if (reg_addr !== 16'd5 || err_count !== 8'd0) begin miscompares++; $display("FAIL write hold/err: got %h/%0d expected 5/0", reg_addr, err_count); end
    endtask

    task automatic test_read();
        logic [31:0] v;
        do_reset();
        or_mode   = 1;
        rsp_en    = 1'b1;
        rsp_junk  = 1'b1;
        rsp_delay = 2;
        rsp_val   = 32'h00000080;
        v         = rsp_val;
        send_word(RD_HDR);
        send_word(32'h40);
        wait_out(4, 200);
        repeat (10) @(negedge clk);
        vectors++; if (got_rd.size() != 1 || got_rd[0] !== 16'd16) begin miscompares++; $display("FAIL read strobe: got %0d strobes addr %h expected 1 addr 0010", got_rd.size(), reg_addr); end
        vectors++; if (got_out.size() != 4) begin miscompares++; $display("FAIL read byte count: got %0d expected 4", got_out.size()); end
        for (int i = 0; i < 4 && i < got_out.size(); i++) begin
            vectors++; if (got_out[i] !== model_byte(v, i)) begin miscompares++; $display("FAIL read byte%0d: got %h expected %h", i, got_out[i], model_byte(v, i)); end
        end
        vectors++; if (hold_viol != 0) begin miscompares++; $display("FAIL read hold: got %0d violations expected 0", hold_viol); end
        vectors++; if (got_wr.size() != 0 || err_count !== 8'd0) begin miscompares++; $display("FAIL read side effects: got wr=%0d err=%0d expected 0/0", got_wr.size(), err_count); end
        rsp_junk = 1'b0;
        or_mode  = 0;
    endtask

    task automatic test_bad_header();
        do_reset();
        send_word(32'h12345678);
        send_word(WR_HDR);
        send_word(32'h24);
        send_word(32'hCAFEF00D);
        wait_wr(1);
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL bad_hdr err: got %0d expected 1", err_count); end
        vectors++; if (got_wr.size() != 1) begin miscompares++; $display("FAIL bad_hdr pulses: got %0d expected 1", got_wr.size()); end
        if (got_wr.size() >= 1) begin
            vectors++; if (got_wr[0] !== {16'd9, 32'hCAFEF00D}) begin miscompares++; $display("FAIL bad_hdr bus: got %h expected %h", got_wr[0], {16'd9, 32'hCAFEF00D}); end
        end
    endtask

    task automatic test_truncated();
        logic [31:0] v;
        do_reset();
        send_word(WR_HDR);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (T - 2) @(negedge clk);
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL trunc early: got %0d expected 0", err_count); end
        repeat (5) @(negedge clk);
        vectors++; if (err_count !== 8'd1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL trunc timeout: got err=%0d rdy=%b expected 1/1", err_count, in_ready); end
        rsp_en = 1'b1; rsp_delay = 1; rsp_val = $urandom; v = rsp_val;
        send_word(RD_HDR);
        send_word(32'h100);
        wait_out(4, 200);
        vectors++; if (got_rd.size() != 1 || got_rd[0] !== model_addr(32'h100)) begin miscompares++; $display("FAIL trunc follow-up rd: got %0d strobes addr %h expected 1 addr %h", got_rd.size(), reg_addr, model_addr(32'h100)); end
        vectors++; if (got_out.size() != 4 || {got_out[3], got_out[2], got_out[1], got_out[0]} !== v) begin miscompares++; $display("FAIL trunc follow-up data: got %0d bytes expected %h", got_out.size(), v); end
        vectors++; if (got_wr.size() != 0 || err_count !== 8'd1) begin miscompares++; $display("FAIL trunc side effects: got wr=%0d err=%0d expected 0/1", got_wr.size(), err_count); end
    endtask

    task automatic test_read_timeout();
        do_reset();
        rsp_en = 1'b0;
        send_word(RD_HDR);
        send_word(32'h0);
        wait_out(4, T + 60);
        vectors++; if (got_out.size() != 4) begin miscompares++; $display("FAIL rd_timeout count: got %0d expected 4", got_out.size()); end
        for (int i = 0; i < 4 && i < got_out.size(); i++) begin
            vectors++; if (got_out[i] !== model_byte(32'hDEADBEEF, i)) begin miscompares++; $display("FAIL rd_timeout byte%0d: got %h expected %h", i, got_out[i], model_byte(32'hDEADBEEF, i)); end
        end
        vectors++; if (err_count !== 8'd1 || reg_addr !== 16'd0) begin miscompares++; $display("FAIL rd_timeout err/addr: got %0d/%h expected 1/0", err_count, reg_addr); end
        rsp_en = 1'b1;
    endtask

    task automatic test_reset_mid_send();
        int k = 0;
        int oc = 0;
        do_reset();
        or_mode = 0; rsp_en = 1'b1; rsp_delay = 1; rsp_val = 32'h44332211;
        send_word(RD_HDR);
        send_word(32'h8);
        while (got_out.size() < 2 && k < 300) begin
            @(posedge clk);
            #2;
            k++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) oc++;
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        vectors++; if (oc != 0) begin miscompares++; $display("FAIL rst_send out_valid: got %0d high cycles expected 0", oc); end
        vectors++; if (got_out.size() != 2) begin miscompares++; $display("FAIL rst_send bytes: got %0d expected 2", got_out.size()); end
        vectors++; if (got_rd.size() != 1 || err_count !== 8'd0) begin miscompares++; $display("FAIL rst_send rd/err: got %0d/%0d expected 1/0", got_rd.size(), err_count); end
        send_word(WR_HDR);
        send_word(32'hC);
        send_word(32'h5A5A1234);
        wait_wr(1);
        vectors++; if (got_wr.size() != 1 || got_wr[0] !== {16'd3, 32'h5A5A1234}) begin miscompares++; $display("FAIL rst_send follow-up: got %0d writes addr %h expected 1 addr 0003", got_wr.size(), reg_addr); end
    endtask

    task automatic test_err_saturate();
        do_reset();
        gap_max = 0;
        for (int i = 0; i < 257; i++) send_word(32'h0BAD0000 + i);
        repeat (3) @(negedge clk);
        vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL err_saturate: got %0d expected 255", err_count); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] exp_wr[$];
        logic [15:0] exp_rd[$];
        logic [7:0]  exp_out[$];
        logic [31:0] baddr, data;
        do_reset();
        gap_max = 2;
        or_mode = 2;
        rsp_en  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            baddr = $urandom;
            data  = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                exp_wr.push_back({model_addr(baddr), data});
                send_word(WR_HDR);
                send_word(baddr);
                send_word(data);
            end else begin
                rsp_val   = data;
                rsp_delay = int'($urandom_range(1, 4));
                rsp_junk  = 1'($urandom_range(0, 1));
                exp_rd.push_back(model_addr(baddr));
                for (int i = 0; i < 4; i++) exp_out.push_back(model_byte(data, i));
                send_word(RD_HDR);
                send_word(baddr);
                wait_out(exp_out.size(), 300);
            end
        end
        wait_wr(exp_wr.size());
        vectors++; if (got_wr.size() != exp_wr.size() || got_rd.size() != exp_rd.size() || got_out.size() != exp_out.size())
            begin miscompares++; $display("FAIL b2b counts: got %0d/%0d/%0d expected %0d/%0d/%0d", got_wr.size(), got_rd.size(), got_out.size(), exp_wr.size(), exp_rd.size(), exp_out.size()); end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            vectors++; if (got_wr[i] !== exp_wr[i]) begin miscompares++; $display("FAIL b2b wr%0d: got %h expected %h", i, got_wr[i], exp_wr[i]); end
        end
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
            vectors++; if (got_rd[i] !== exp_rd[i]) begin miscompares++; $display("FAIL b2b rd%0d: got %h expected %h", i, got_rd[i], exp_rd[i]); end
        end
        for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
            vectors++; if (got_out[i] !== exp_out[i]) begin miscompares++; $display("FAIL b2b out%0d: got %h expected %h", i, got_out[i], exp_out[i]); end
        end
        vectors++; if (hold_viol != 0 || err_count !== 8'd0) begin miscompares++; $display("FAIL b2b hold/err: got %0d/%0d expected 0/0", hold_viol, err_count); end
        rsp_junk = 1'b0;
        or_mode  = 0;
        gap_max  = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_header();
        test_truncated();
        test_read_timeout();
        test_reset_mid_send();
        test_err_saturate();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
